apb4_gpio_irq: RTL

- Parametrised next-generation APB4 GPIO controller.
- Adds per-pin interrupts (level or edge, selectable polarity), atomic set/clear of outputs, input synchronisation, and a prescaled glitch filter.
- Sits between the APB4 peripheral bus and the tri-state pad ring; `gpio_out_o`/`gpio_dir_o` drive pad `i_i`/`oen_i`, and `gpio_in_i` comes from pad `c_o`.

---
 rtl/apb4_gpio_irq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/apb4_gpio_irq.sv
// APB4 GPIO controller: synchronised and filtered inputs, per-pin level/edge interrupts, atomic OUT set/clear.
// Define APB4_GPIO_DBNC_EN to build the DBNC prescaler and glitch filter; otherwise offset 0x20 reads 0.
module apb4_gpio_irq #(
    parameter int GPIO_NUM   = 32,
    parameter int DBNC_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [11:0]         paddr_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [31:0]         pwdata_i,
    output logic                pready_o,
    output logic [31:0]         prdata_o,
    output logic                pslverr_o,
    input  logic [GPIO_NUM-1:0] gpio_in_i,
    output logic [GPIO_NUM-1:0] gpio_out_o,
    output logic [GPIO_NUM-1:0] gpio_dir_o,
    output logic [GPIO_NUM-1:0] gpio_iof_o,
    output logic                irq_o
);

    localparam logic [3:0] A_DIR     = 4'd0;
    localparam logic [3:0] A_IN      = 4'd1;
    localparam logic [3:0] A_OUT     = 4'd2;
    localparam logic [3:0] A_IOF     = 4'd3;
    localparam logic [3:0] A_INTEN   = 4'd4;
    localparam logic [3:0] A_INTTYPE = 4'd5;
    localparam logic [3:0] A_INTPOL  = 4'd6;
    localparam logic [3:0] A_INTSTAT = 4'd7;
    localparam logic [3:0] A_DBNC    = 4'd8;
    localparam logic [3:0] A_OUTSET  = 4'd9;
    localparam logic [3:0] A_OUTCLR  = 4'd10;

    logic [3:0]          idx;
    logic                wr_en, rd_en, addr_ok;
    logic [GPIO_NUM-1:0] wdata;
    logic                unused_bits;

    assign idx         = paddr_i[5:2];
    assign addr_ok     = (idx <= A_OUTCLR);
    assign wr_en       = psel_i & penable_i & pwrite_i & addr_ok;
    assign rd_en       = psel_i & penable_i & ~pwrite_i;
    assign wdata       = pwdata_i[GPIO_NUM-1:0];
    assign pready_o    = 1'b1;
    assign pslverr_o   = psel_i & penable_i & ~addr_ok;
    assign unused_bits = ^{paddr_i[11:6], paddr_i[1:0], pwdata_i};

    logic [GPIO_NUM-1:0] dir_q, dir_d, out_q, out_d, iof_q, iof_d;
    logic [GPIO_NUM-1:0] inten_q, inten_d, inttype_q, inttype_d, intpol_q, intpol_d;
    logic [GPIO_NUM-1:0] intstat_q, intstat_d, w1c;
    logic [GPIO_NUM-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [GPIO_NUM-1:0] filt, cond;
    logic                irq_q, irq_d;
    logic [31:0]         dbnc_rd, rdata;

`ifdef APB4_GPIO_DBNC_EN
    logic [DBNC_WIDTH-1:0] dbnc_q, dbnc_d, cnt_q, cnt_d;
    logic [GPIO_NUM-1:0]   samp_q, samp_d, filt_q, filt_d, same;
    logic                  tick;

    assign same = ~(sync2_q ^ samp_q);

    always_comb begin
        dbnc_d = dbnc_q;
        cnt_d  = cnt_q;
        samp_d = samp_q;
        filt_d = filt_q;
        tick   = 1'b0;
        if (dbnc_q == '0) begin
            // Track the synchroniser in bypass so enabling the filter starts from a settled value.
            cnt_d  = '0;
            samp_d = sync2_q;
            filt_d = sync2_q;
        end else begin
            tick  = (cnt_q == dbnc_q);
            cnt_d = tick ? '0 : cnt_q + DBNC_WIDTH'(1);
            if (tick) begin
                samp_d = sync2_q;
                filt_d = (same & sync2_q) | (~same & filt_q);
            end
        end
        if (wr_en && idx == A_DBNC) begin
            dbnc_d = pwdata_i[DBNC_WIDTH-1:0];
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dbnc_q <= '0;
            cnt_q  <= '0;
            samp_q <= '0;
            filt_q <= '0;
        end else begin
            dbnc_q <= dbnc_d;
            cnt_q  <= cnt_d;
            samp_q <= samp_d;
            filt_q <= filt_d;
        end
    end

    assign filt    = (dbnc_q == '0) ? sync2_q : filt_q;
    assign dbnc_rd = 32'(dbnc_q);
`else
    assign filt    = sync2_q;
    assign dbnc_rd = '0;
`endif

    generate
        for (genvar gi = 0; gi < GPIO_NUM; gi++) begin : g_cond
            logic edge_hit;
            assign edge_hit  = intpol_q[gi] ? (~filt[gi] & prev_q[gi]) : (filt[gi] & ~prev_q[gi]);
            assign cond[gi]  = inten_q[gi] & (inttype_q[gi] ? edge_hit : (filt[gi] ^ intpol_q[gi]));
        end
    endgenerate

    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        iof_d     = iof_q;
        inten_d   = inten_q;
        inttype_d = inttype_q;
        intpol_d  = intpol_q;
        w1c       = '0;
        if (wr_en) begin
            case (idx)
                A_DIR:     dir_d     = wdata;
                A_OUT:     out_d     = wdata;
                A_IOF:     iof_d     = wdata;
                A_INTEN:   inten_d   = wdata;
                A_INTTYPE: inttype_d = wdata;
                A_INTPOL:  intpol_d  = wdata;
                A_INTSTAT: w1c       = wdata;
                A_OUTSET:  out_d     = out_q | wdata;
                A_OUTCLR:  out_d     = out_q & ~wdata;
                default:   ;
            endcase
        end
        // A source that is active in the clearing cycle keeps its bit set.
        intstat_d = (intstat_q & ~w1c) | cond;
        sync1_d   = gpio_in_i;
        sync2_d   = sync1_q;
        prev_d    = filt;
        irq_d     = |(intstat_q & inten_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dir_q     <= '0;
            out_q     <= '0;
            iof_q     <= '0;
            inten_q   <= '0;
            inttype_q <= '0;
            intpol_q  <= '0;
            intstat_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            iof_q     <= iof_d;
            inten_q   <= inten_d;
            inttype_q <= inttype_d;
            intpol_q  <= intpol_d;
            intstat_q <= intstat_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (idx)
                A_DIR:     rdata = 32'(dir_q);
                A_IN:      rdata = 32'(filt);
                A_OUT:     rdata = 32'(out_q);
                A_IOF:     rdata = 32'(iof_q);
                A_INTEN:   rdata = 32'(inten_q);
                A_INTTYPE: rdata = 32'(inttype_q);
                A_INTPOL:  rdata = 32'(intpol_q);
                A_INTSTAT: rdata = 32'(intstat_q);
                A_DBNC:    rdata = dbnc_rd;
                default:   rdata = '0;
            endcase
        end
    end

    assign prdata_o   = rdata;
    assign gpio_out_o = out_q;
    assign gpio_dir_o = dir_q;
    assign gpio_iof_o = iof_q;
    assign irq_o      = irq_q;

endmodule
